// File: rtl/encoder_pkg.sv
// Shared definitions for the quadrature front end: controller states and
// the clockwise Gray-order classification of a {prev, cur} channel pair.
package encoder_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } encState_t;

    typedef enum logic [1:0] {
        TR_NONE    = 2'd0,
        TR_NEXT    = 2'd1,
        TR_PREV    = 2'd2,
        TR_ILLEGAL = 2'd3
    } quadTrans_t;

    // Position of a {A,B} pair in the clockwise order 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] grayIndex(input logic [1:0] ab);
        logic [1:0] idx;
        case (ab)
            2'b00:   idx = 2'd0;
            2'b10:   idx = 2'd1;
            2'b11:   idx = 2'd2;
            2'b01:   idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Classifies a transition: one step forward in the Gray order is
    // clockwise, one step back is counter-clockwise, two steps means both
    // channels moved at once and the direction cannot be known.
    function automatic quadTrans_t classifyTransition(input logic [1:0] prevAb,
                                                      input logic [1:0] curAb);
        logic [1:0] delta;
        quadTrans_t tr;
        delta = grayIndex(curAb) - grayIndex(prevAb);
        case (delta)
            2'd0:    tr = TR_NONE;
            2'd1:    tr = TR_NEXT;
            2'd3:    tr = TR_PREV;
            default: tr = TR_ILLEGAL;
        endcase
        return tr;
    endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// One encoder channel: multi-flop synchroniser followed by a persistence
// filter. The filtered level only follows the synchronised input after it
// has disagreed for FILT_CYCLES consecutive clocks.
module quad_glitch_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 16
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic rawIn,
    output logic filtOut,
    output logic stable
);

    localparam int CNT_W = $clog2(FILT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] syncChain_r;
    logic                   synced_s;
    logic [CNT_W-1:0]       cnt_r;
    logic                   filt_r;

    assign synced_s = syncChain_r[SYNC_STAGES-1];
    assign filtOut  = filt_r;
    // The controller uses this to decide when start-up filtering has settled.
    assign stable   = (synced_s == filt_r);

    // Shift the raw level through the synchroniser; nothing else sees rawIn.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            syncChain_r <= '0;
        end else begin
            syncChain_r <= {syncChain_r[SYNC_STAGES-2:0], rawIn};
        end
    end

    // Count consecutive disagreeing cycles; adopt the new level on the last one.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_r  <= '0;
            filt_r <= 1'b0;
        end else if (synced_s == filt_r) begin
            cnt_r  <= '0;
        end else if (cnt_r >= CNT_LAST) begin
            filt_r <= synced_s;
            cnt_r  <= '0;
        end else if (cnt_r != CNT_MAX) begin
            cnt_r  <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r  <= cnt_r;
        end
    end

endmodule

// File: rtl/quadrature_input_conditioner.sv
// Encoder front end: filters both channels, waits for the filters to settle,
// then x4-decodes the clean levels into step/dir/pos and an error pulse.
module quadrature_input_conditioner
    import encoder_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 16,
    parameter int POS_W       = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             a_raw,
    input  logic             b_raw,
    input  logic             pos_clr,
    output logic             signalA,
    output logic             signalB,
    output logic             step,
    output logic             dir,
    output logic [POS_W-1:0] pos,
    output logic             err,
    output logic             ready
);

    localparam int CNT_W = $clog2(FILT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

    encState_t        state_r;
    logic [CNT_W-1:0] stableCnt_r;
    logic [1:0]       prevAb_r;
    logic [1:0]       curAb_s;
    logic             stableA_s;
    logic             stableB_s;
    quadTrans_t       trans_s;

    quad_glitch_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_CYCLES(FILT_CYCLES)
    ) filtA (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .rawIn  (a_raw),
        .filtOut(signalA),
        .stable (stableA_s)
    );

    quad_glitch_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_CYCLES(FILT_CYCLES)
    ) filtB (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .rawIn  (b_raw),
        .filtOut(signalB),
        .stable (stableB_s)
    );

    assign curAb_s = {signalA, signalB};

    // Classify the change between last cycle's filtered pair and this one.
    always_comb begin
        trans_s = TR_NONE;
        trans_s = classifyTransition(prevAb_r, curAb_s);
    end

    // Controller: settle in INIT, then decode steps and errors in RUN.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= INIT;
            stableCnt_r <= '0;
            prevAb_r    <= 2'b00;
            step        <= 1'b0;
            dir         <= 1'b0;
            err         <= 1'b0;
            ready       <= 1'b0;
        end else begin
            step     <= 1'b0;
            err      <= 1'b0;
            prevAb_r <= curAb_s;
            case (state_r)
                INIT: begin
                    if (!(stableA_s && stableB_s)) begin
                        stableCnt_r <= '0;
                    end else if (stableCnt_r >= CNT_LAST) begin
                        stableCnt_r <= '0;
                        ready       <= 1'b1;
                        state_r     <= RUN;
                    end else begin
                        stableCnt_r <= stableCnt_r + CNT_W'(1);
                    end
                end
                RUN: begin
                    case (trans_s)
                        TR_NEXT: begin
                            step <= 1'b1;
                            dir  <= 1'b1;
                        end
                        TR_PREV: begin
                            step <= 1'b1;
                            dir  <= 1'b0;
                        end
                        TR_ILLEGAL: begin
                            err  <= 1'b1;
                        end
                        default: begin
                            step <= 1'b0;
                        end
                    endcase
                end
                default: begin
                    state_r <= INIT;
                end
            endcase
        end
    end

    // Position counter: wraps modulo 2^POS_W; a clear overrides a step.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pos <= '0;
        end else if (pos_clr) begin
            pos <= '0;
        end else if ((state_r == RUN) && (trans_s == TR_NEXT)) begin
            pos <= pos + POS_W'(1);
        end else if ((state_r == RUN) && (trans_s == TR_PREV)) begin
            pos <= pos - POS_W'(1);
        end else begin
            pos <= pos;
        end
    end

endmodule

// File: tb/tb_quadrature_input_conditioner.sv
// Bench for the quadrature front end: directed phases plus random raw
// activity, checked every cycle against a window-based behavioural model.
module tb_quadrature_input_conditioner;

    localparam int SYNC  = 2;
    localparam int FILT  = 16;
    localparam int POS_W = 8;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             a_raw, b_raw, pos_clr;
    logic             signalA, signalB, step, dir, err, ready;
    logic [POS_W-1:0] pos;

    int checks = 0;
    int errors = 0;
    int stepCnt = 0;
    int errCnt = 0;

    quadrature_input_conditioner #(
        .SYNC_STAGES(SYNC),
        .FILT_CYCLES(FILT),
        .POS_W      (POS_W)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .a_raw  (a_raw),
        .b_raw  (b_raw),
        .pos_clr(pos_clr),
        .signalA(signalA),
        .signalB(signalB),
        .step   (step),
        .dir    (dir),
        .pos    (pos),
        .err    (err),
        .ready  (ready)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [SYNC-1:0]  mSyncA, mSyncB;
    logic             mFiltA, mFiltB, mRun, mStep, mDir, mErr, mReady;
    logic [POS_W-1:0] mPos;
    logic [1:0]       mPrev;
    bit               winA[$], winB[$], winS[$];
    int               rotOf[4] = '{0, 3, 1, 2};   // rotation index of {A,B}

    function automatic bit allVal(input bit q[$], input bit v);
        if (q.size() < FILT) return 1'b0;
        foreach (q[i]) if (q[i] != v) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge CLK) begin
        logic       sa, sb, fa, fb;
        logic [1:0] cur;
        int         d;
        if (!RST_N) begin
            mSyncA = '0; mSyncB = '0; mFiltA = 0; mFiltB = 0; mRun = 0;
            mStep = 0; mDir = 0; mErr = 0; mReady = 0; mPos = '0; mPrev = 2'b00;
            winA.delete(); winB.delete(); winS.delete();
        end else begin
            sa = mSyncA[SYNC-1]; sb = mSyncB[SYNC-1];
            fa = mFiltA;         fb = mFiltB;
            cur = {fa, fb};
            winA.push_back(sa); if (winA.size() > FILT) void'(winA.pop_front());
            winB.push_back(sb); if (winB.size() > FILT) void'(winB.pop_front());
            winS.push_back((sa == fa) && (sb == fb));
            if (winS.size() > FILT) void'(winS.pop_front());
            mStep = 0; mErr = 0; d = 0;
            if (mRun && (mPrev != cur)) begin
                d = (rotOf[cur] - rotOf[mPrev] + 4) % 4;
                if (d == 1) begin mStep = 1; mDir = 1; end
                else if (d == 3) begin mStep = 1; mDir = 0; end
                else mErr = 1;
            end
            if (pos_clr) mPos = '0;
            else if (d == 1) mPos = mPos + 1'b1;
            else if (d == 3) mPos = mPos - 1'b1;
            if (!mRun && allVal(winS, 1'b1)) begin mRun = 1; mReady = 1; end
            mPrev = cur;
            if (allVal(winA, !fa)) mFiltA = !fa;
            if (allVal(winB, !fb)) mFiltB = !fb;
            mSyncA = {mSyncA[SYNC-2:0], a_raw};
            mSyncB = {mSyncB[SYNC-2:0], b_raw};
        end
    end

    // Compare DUT against the model every cycle outside reset.
    always @(negedge CLK) begin
        if (RST_N) begin
            check("signalA", signalA, mFiltA);
            check("signalB", signalB, mFiltB);
            check("step",    step,    mStep);
            check("dir",     dir,     mDir);
            check("pos",     pos,     mPos);
            check("err",     err,     mErr);
            check("ready",   ready,   mReady);
            check("stepErrExclusive", step & err, 1'b0);
            if (step) stepCnt++;
            if (err) errCnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic setAB(input logic [1:0] ab, input int hold);
        a_raw = ab[1];
        b_raw = ab[0];
        tick(hold);
    endtask

    initial begin
        logic [1:0] cw[4];
        int readyCyc, lat, s0, e0, s;
        cw[0] = 2'b00; cw[1] = 2'b10; cw[2] = 2'b11; cw[3] = 2'b01;

        RST_N = 1'b0; a_raw = 1'b1; b_raw = 1'b1; pos_clr = 1'b0;
        tick(3);
        check("rstReady", ready, 1'b0);
        check("rstPos", pos, 8'h00);
        check("rstSignalA", signalA, 1'b0);
        RST_N = 1'b1;

        // Resting at 11: ready after SYNC + 2*FILT edges, no pulses.
        readyCyc = -1;
        for (int i = 1; i <= 50; i++) begin
            tick(1);
            if (ready && readyCyc < 0) readyCyc = i;
        end
        check("readyCycle", readyCyc, 34);
        check("initSignals", {signalA, signalB}, 2'b11);
        check("initNoPulses", stepCnt + errCnt, 0);

        // Walk 11 -> 01 -> 00 then clear.
        setAB(2'b01, 40);
        setAB(2'b00, 40);
        check("walkToZero", pos, 8'h02);
        pos_clr = 1'b1; tick(1); pos_clr = 1'b0; tick(1);
        check("clear", pos, 8'h00);

        // One clockwise revolution; measure filter latency on A.
        s0 = stepCnt;
        a_raw = 1'b1; lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (signalA && lat < 0) lat = i;
        end
        check("latencyA", lat, 18);
        setAB(2'b11, 40);
        setAB(2'b01, 40);
        setAB(2'b00, 40);
        check("cwSteps", stepCnt - s0, 4);
        check("cwPos", pos, 8'h04);
        check("cwDir", dir, 1'b1);

        // Reverse revolution from zero.
        pos_clr = 1'b1; tick(1); pos_clr = 1'b0;
        s0 = stepCnt;
        setAB(2'b01, 40);
        setAB(2'b11, 40);
        setAB(2'b10, 40);
        setAB(2'b00, 40);
        check("ccwSteps", stepCnt - s0, 4);
        check("ccwPos", pos, 8'hFC);
        check("ccwDir", dir, 1'b0);

        // Glitches: 10 cycles rejected, 16 cycles accepted (two steps).
        s0 = stepCnt;
        setAB(2'b10, 10);
        setAB(2'b00, 40);
        check("glitch10Steps", stepCnt - s0, 0);
        setAB(2'b10, 16);
        setAB(2'b00, 60);
        check("pulse16Steps", stepCnt - s0, 2);
        check("pulse16Pos", pos, 8'hFC);

        // Both channels at once: error, no step, pos held.
        s0 = stepCnt; e0 = errCnt;
        setAB(2'b11, 40);
        check("illegalErr", errCnt - e0, 1);
        check("illegalSteps", stepCnt - s0, 0);
        check("illegalPos", pos, 8'hFC);
        setAB(2'b00, 40);
        check("illegalBackErr", errCnt - e0, 2);

        // Wrap across the signed boundary.
        pos_clr = 1'b1; tick(1); pos_clr = 1'b0;
        s = 0;
        for (int k = 0; k < 127; k++) begin
            s = (s + 1) % 4;
            setAB(cw[s], 20);
        end
        check("pos7F", pos, 8'h7F);
        s = (s + 1) % 4;
        setAB(cw[s], 20);
        check("pos80", pos, 8'h80);

        // Clear coinciding with a step: clear wins, step still reported.
        s0 = stepCnt;
        pos_clr = 1'b1;
        s = (s + 1) % 4;
        setAB(cw[s], 25);
        pos_clr = 1'b0; tick(1);
        check("clrStepPos", pos, 8'h00);
        check("clrStepCount", stepCnt - s0, 1);
        check("clrStepDir", dir, 1'b1);

        // Random raw activity, including short glitches and clears.
        for (int k = 0; k < 300; k++) begin
            a_raw   = 1'($urandom_range(0, 1));
            b_raw   = 1'($urandom_range(0, 1));
            pos_clr = ($urandom_range(0, 15) == 0);
            tick($urandom_range(1, 30));
        end
        pos_clr = 1'b0;

        // Reset mid-operation with the encoder resting at 11.
        RST_N = 1'b0; a_raw = 1'b1; b_raw = 1'b1;
        tick(2);
        check("midRstPos", pos, 8'h00);
        check("midRstReady", ready, 1'b0);
        RST_N = 1'b1;
        e0 = errCnt;
        tick(60);
        check("midRstNoErr", errCnt - e0, 0);
        check("midRstReadyAgain", ready, 1'b1);

        for (int k = 0; k < 100; k++) begin
            a_raw = 1'($urandom_range(0, 1));
            b_raw = 1'($urandom_range(0, 1));
            tick($urandom_range(1, 40));
        end
        tick(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/quadrature_input_conditioner.md
Name: quadrature_input_conditioner

Overview:
- Front-end stage directly upstream of the encoder direction/speed logic.
- Takes raw, asynchronous encoder channels A and B and synchronises each to CLK.
- Glitch-filters each channel and emits clean signalA/signalB levels for the downstream stage.
- Also performs x4 quadrature decoding: one-cycle step pulse, direction, signed position count, and an illegal-transition error pulse.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of each input synchroniser; minimum 2.
- FILT_CYCLES, 16: consecutive stable cycles required before a filtered level may change; minimum 1.
- POS_W, 16: width of the position counter (two's complement).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- a_raw  in  1  raw encoder channel A, asynchronous to CLK.
- b_raw  in  1  raw encoder channel B, asynchronous to CLK.
- pos_clr  in  1  synchronous clear of pos.
- signalA  out  1  filtered channel A level, for the direction stage.
- signalB  out  1  filtered channel B level, for the direction stage.
- step  out  1  one-cycle pulse per valid quadrature edge.
- dir  out  1  direction of the last valid step: 1 = clockwise (A leads B), 0 = counter-clockwise.
- pos  out  POS_W  signed position count.
- err  out  1  one-cycle pulse on an illegal transition.
- ready  out  1  high once initial filtering has completed.

Behaviour:
- Reset (RST_N=0, async): every synchroniser flop, filter counter, signalA, signalB, step, dir, pos, err and ready go to 0; state = INIT.
- Synchroniser: a_raw and b_raw each pass through SYNC_STAGES flops; no other logic samples the raw inputs.
- Filter, per channel:
  - cnt clears to 0 whenever the synced bit equals the filtered bit.
  - Otherwise cnt increments.
  - When cnt reaches FILT_CYCLES-1 while still differing, the filtered bit takes the synced value on that edge and cnt clears.
  - Any pulse shorter than FILT_CYCLES cycles is rejected entirely.
  - cnt width = clog2(FILT_CYCLES)+1 and saturates; it never wraps.
- State machine:
  - INIT: both filters run. signalA/signalB are loaded the same way, but no step or err is generated.
  - Leave INIT when both channels have had synced==filtered for FILT_CYCLES consecutive cycles after any load. Then set ready=1 and go to RUN.
  - RUN: decode on each cycle where prev={A,B} differs from cur={filtered A, filtered B}. prev updates every RUN cycle.
  - Clockwise sequence: 00→10→11→01→00. On a clockwise transition: step=1, dir=1, pos+1.
  - Reverse sequence: step=1, dir=0, pos-1.
  - Both bits changing in the same cycle: err=1, step=0, pos and dir unchanged.
  - RUN never returns to INIT except through reset.
- Latency: raw edge to filtered output = SYNC_STAGES + FILT_CYCLES cycles. step/dir/pos/err are registered one cycle after the filtered output changes.
- pos arithmetic: modulo 2^POS_W. 0x7FFF+1 → 0x8000 and 0x0000-1 → 0xFFFF for POS_W=16; no saturation and no flag.
- pos_clr:
  - Sets pos to 0 on the next edge.
  - If pos_clr and a step coincide, the clear wins (pos=0), but step and dir still update.
  - pos_clr has no effect on the filters or the state.
- Reset mid-operation: returns immediately to the reset values. The INIT sequence repeats, so a resting encoder at 11 produces no spurious err.
- step and err are never high in the same cycle.

Decomposition:
- Shared package (encoder_pkg): state enum {INIT, RUN}; a function encoding the clockwise Gray order (00,10,11,01) that returns next/prev/illegal for a {prev,cur} pair.
- One sub-module, quad_glitch_filter: the synchroniser plus per-channel filter counter, parameterised by SYNC_STAGES and FILT_CYCLES, instantiated twice.
- The top module holds the state machine, decoder and position counter.

Test Plan:
- Reset with a_raw=b_raw=1 held → ready=1 at cycle SYNC_STAGES+2*FILT_CYCLES (±1); signalA=signalB=1; no step or err pulses.
- One full clockwise cycle 00→10→11→01→00, phases 40 cycles apart (FILT_CYCLES=16) → 4 step pulses, dir=1, pos=4; signalA rises 18 cycles after a_raw rises.
- Reverse sequence 00→01→11→10→00 from pos=0 → 4 steps, dir=0, pos=0xFFFC.
- 10-cycle glitch on a_raw in RUN → signalA unchanged, no step; a 16-cycle pulse → exactly 2 steps.
- a_raw and b_raw toggled together 00→11 → one err pulse, step=0, pos unchanged.
- pos=0x7FFF, one clockwise step → 0x8000; pos_clr asserted in the same cycle as a step → pos=0, step=1.
